// File: rtl/shift_r_pkg.sv
// Shared constants and types for the serial-in/parallel-out receive front end.
package shift_r_pkg;

  localparam int SR_WIDTH_DEF = 8;
  localparam logic [SR_WIDTH_DEF-1:0] SR_PATTERN_DEF = 8'b0100_1110;

  // Parallel word as seen by downstream deserialiser consumers.
  typedef logic [SR_WIDTH_DEF-1:0] sr_word_t;

  // Width of a counter that must hold values 0..w inclusive.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shift_r_if.sv
// Serial input and parallel/status outputs of the shift register.
interface shift_r_if
  import shift_r_pkg::*;
#(
  parameter int WIDTH = SR_WIDTH_DEF,
  parameter int CW    = cnt_w(WIDTH)
);

  logic             SR_IN;
  logic [WIDTH-1:0] SR_O;
  logic [CW-1:0]    SR_CNT;
  logic             SR_FULL;
  logic             SR_MATCH;

  // Shift register side: consumes the serial bit, produces word and status.
  modport slave  (input SR_IN, output SR_O, SR_CNT, SR_FULL, SR_MATCH);
  // Stream source / consumer side.
  modport master (output SR_IN, input SR_O, SR_CNT, SR_FULL, SR_MATCH);

endinterface

// File: rtl/shift_r.sv
// Serial-in, parallel-out shift register with saturating fill count and
// fixed-pattern detect. Newest bit lands in bit 0.
module shift_r
  import shift_r_pkg::*;
#(
  parameter int               WIDTH   = SR_WIDTH_DEF,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(SR_PATTERN_DEF)
) (
  input  logic     SR_CLK,
  input  logic     SR_RST,
  shift_r_if.slave sr
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] sr_d, sr_q;
  logic [CW-1:0]    cnt_d, cnt_q;
  logic             full;

  // Next state: shift left every edge, count up until the word is filled.
  always_comb begin
    sr_d  = {sr_q[WIDTH-2:0], sr.SR_IN};
    cnt_d = cnt_q;
    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  // State registers; reset discards any partial word immediately.
  always_ff @(posedge SR_CLK or posedge SR_RST) begin
    if (SR_RST) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  // Match is gated by full so reset zeros never hit an all-zero pattern.
  assign full        = (cnt_q == CNT_MAX);
  assign sr.SR_O     = sr_q;
  assign sr.SR_CNT   = cnt_q;
  assign sr.SR_FULL  = full;
  assign sr.SR_MATCH = full && (sr_q == PATTERN);

endmodule

// File: tb/tb_shift_r.sv
// Self-checking bench for shift_r: directed scenarios plus random streams,
// compared against a bit-history reference model.
module tb_shift_r;
  import shift_r_pkg::*;

  localparam int W = 8;
  localparam logic [W-1:0] PAT = 8'h4E;

  logic clk, rst, rst_z;
  int   checks, failures;
  bit   hist[$];

  shift_r_if #(.WIDTH(W)) sr_if ();
  shift_r_if #(.WIDTH(W)) z_if ();

  shift_r #(.WIDTH(W), .PATTERN(PAT)) dut (
    .SR_CLK(clk), .SR_RST(rst), .sr(sr_if.slave)
  );

  shift_r #(.WIDTH(W), .PATTERN('0)) dut_z (
    .SR_CLK(clk), .SR_RST(rst_z), .sr(z_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the word is simply the last W bits received, newest at bit 0.
  function automatic logic [W-1:0] exp_word();
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++)
      if (i < hist.size()) w[i] = hist[hist.size()-1-i];
    return w;
  endfunction

  function automatic int exp_cnt();
    return (hist.size() < W) ? hist.size() : W;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic full;
    full = (exp_cnt() == W);
    chk({tag, ".o"},     32'(sr_if.SR_O),     32'(exp_word()));
    chk({tag, ".cnt"},   32'(sr_if.SR_CNT),   32'(exp_cnt()));
    chk({tag, ".full"},  32'(sr_if.SR_FULL),  32'(full));
    chk({tag, ".match"}, 32'(sr_if.SR_MATCH), 32'(full && (exp_word() == PAT)));
  endtask

  // Called at a falling edge: drive the bit, let one rising edge shift it in,
  // then check at the following falling edge.
  task automatic step(input logic b, input string tag);
    sr_if.SR_IN = b;
    @(posedge clk);
    hist.push_back(b);
    @(negedge clk);
    check_all(tag);
  endtask

  // Called at a falling edge (mid-clock): reset must act without a clock edge,
  // and a rising edge while held must be ignored.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    hist.delete();
    check_all({tag, ".async"});
    sr_if.SR_IN = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all({tag, ".hold"});
    rst = 1'b0;
  endtask

  initial begin
    logic [19:0] sat_bits;
    logic [7:0]  fill_bits;
    logic [3:0]  cont_bits;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    rst_z    = 1'b1;
    sr_if.SR_IN = 1'b0;
    z_if.SR_IN  = 1'b0;
    repeat (2) @(negedge clk);
    check_all("por");
    rst = 1'b0;

    // Random stream, long enough to saturate and roll the word many times.
    for (int i = 0; i < 30; i++) step(1'($urandom_range(1)), "rnd_a");

    // Mid-clock reset with a nonzero word (force a 1 in first).
    step(1'b1, "pre_rst");
    chk("pre_rst.nonzero", 32'(sr_if.SR_O != '0), 32'd1);
    do_reset("rst_mid");
    chk("rst.o_zero", 32'(sr_if.SR_O), 32'h00);

    // Fill with the sync pattern, MSB first.
    fill_bits = 8'b0100_1110;
    for (int i = 7; i >= 0; i--) begin
      step(fill_bits[i], "fill");
      if (i == 1) begin
        chk("fill7.full",  32'(sr_if.SR_FULL),  32'd0);
        chk("fill7.match", 32'(sr_if.SR_MATCH), 32'd0);
      end
    end
    chk("fill8.o",     32'(sr_if.SR_O),     32'h4E);
    chk("fill8.cnt",   32'(sr_if.SR_CNT),   32'd8);
    chk("fill8.full",  32'(sr_if.SR_FULL),  32'd1);
    chk("fill8.match", 32'(sr_if.SR_MATCH), 32'd1);

    // Continue past full.
    cont_bits = 4'b0111;
    for (int i = 3; i >= 0; i--) step(cont_bits[i], "cont");
    chk("cont.o",     32'(sr_if.SR_O),     32'hE7);
    chk("cont.cnt",   32'(sr_if.SR_CNT),   32'd8);
    chk("cont.match", 32'(sr_if.SR_MATCH), 32'd0);

    // Saturation: 20 bits from a clean start.
    do_reset("rst_sat");
    sat_bits = 20'b0100_1110_0111_0101_0011;
    for (int i = 19; i >= 0; i--) step(sat_bits[i], "sat");
    chk("sat.o",   32'(sr_if.SR_O),   32'h53);
    chk("sat.cnt", 32'(sr_if.SR_CNT), 32'd8);

    // Reset after 5 shifts, then a single 1.
    do_reset("rst_p5");
    for (int i = 0; i < 5; i++) step(1'($urandom_range(1)), "p5");
    do_reset("rst_mid5");
    step(1'b1, "one");
    chk("one.o",   32'(sr_if.SR_O),   32'h01);
    chk("one.cnt", 32'(sr_if.SR_CNT), 32'd1);

    // Random streams with random reset points.
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(15, 1);
      for (int i = 0; i < n; i++) step(1'($urandom_range(1)), "rnd_b");
      do_reset("rnd_rst");
    end
    for (int i = 0; i < 12; i++) step(1'($urandom_range(1)), "rnd_c");

    // All-zero pattern guard on the second instance.
    chk("z.rst_match", 32'(z_if.SR_MATCH), 32'd0);
    rst_z = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("z.match_e%0d", e), 32'(z_if.SR_MATCH), 32'(e >= 8));
      chk($sformatf("z.cnt_e%0d", e),   32'(z_if.SR_CNT),   32'(e >= 8 ? 8 : e));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
